// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit BRAM back end:
//   - access size encodings (SIZE_B / SIZE_H / SIZE_W, SIZE_X is illegal)
//   - controller state enum lsu_state_t
//   - store lane helpers: store_we(), store_din()
//   - alignment check: misaligned()
// No ports (package).
// -----------------------------------------------------------------------------
package lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RD_WAIT,
    ST_RESP,
    ST_ERR
  } lsu_state_t;

  // Byte write-enable mask for a store of the given size at byte offset addr_lo.
  function automatic logic [3:0] store_we(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
    logic [3:0] mask;
    case (size)
      SIZE_B:  mask = 4'b0001 << addr_lo;
      SIZE_H:  mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      SIZE_W:  mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  // Replicate the right-aligned store data across every lane it could occupy,
  // so the write-enable mask alone picks the destination bytes.
  function automatic logic [31:0] store_din(input logic [1:0]  size,
                                            input logic [31:0] wdata);
    logic [31:0] din;
    case (size)
      SIZE_B:  din = {4{wdata[7:0]}};
      SIZE_H:  din = {2{wdata[15:0]}};
      default: din = wdata;
    endcase
    return din;
  endfunction

  // Natural-alignment check; bytes are always aligned.
  function automatic logic misaligned(input logic [1:0] size,
                                      input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SIZE_H:  bad = addr_lo[0];
      SIZE_W:  bad = (addr_lo != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_bram_ctrl_load_align.sv
// -----------------------------------------------------------------------------
// lsu_load_align
// Combinational load-data aligner: selects the addressed byte/half lane of a
// BRAM word and sign- or zero-extends it to 32 bits. Words pass unchanged.
// Ports:
//   word      in  32  raw BRAM read word
//   addr      in  2   byte offset within the word
//   size      in  2   access size (SIZE_B / SIZE_H / SIZE_W)
//   zero_ext  in  1   1 = zero-extend (LBU/LHU), 0 = sign-extend
//   result    out 32  aligned, extended load data
// -----------------------------------------------------------------------------
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        zero_ext,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        sign_bit;

  always_comb begin
    byte_lane = word[{addr, 3'b000} +: 8];
    half_lane = addr[1] ? word[31:16] : word[15:0];
    sign_bit  = 1'b0;
    result    = word;
    case (size)
      SIZE_B: begin
        sign_bit = byte_lane[7] & ~zero_ext;
        result   = {{24{sign_bit}}, byte_lane};
      end
      SIZE_H: begin
        sign_bit = half_lane[15] & ~zero_ext;
        result   = {{16{sign_bit}}, half_lane};
      end
      default: result = word;
    endcase
  end

endmodule

// File: rtl/lsu_bram_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_bram_ctrl
// Load/store unit back end driving one data-memory BRAM port. Takes a single
// CPU request over valid/ready, issues one BRAM access (or rejects it with an
// error response), and returns a one-cycle response pulse.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    request handshake (ready only in IDLE)
//   req_we, req_size,        store flag, access size, zero-extend flag,
//   req_unsigned, req_addr,  byte address, right-aligned store data
//   req_wdata
//   rsp_valid, rsp_rdata,    one-cycle response, extended load data,
//   rsp_err                  error flag (misaligned / out of range / bad size)
//   bram_addr, bram_din,     BRAM word address, write data, read data
//   bram_dout
//   bram_en, bram_we,        BRAM enable, byte write enables,
//   bram_reset               output-register reset (follows rst)
// -----------------------------------------------------------------------------
module lsu_bram_ctrl
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic                  bram_en,
  output logic [3:0]            bram_we,
  output logic                  bram_reset
);

  lsu_state_t state_reg, state_next;

  logic                  we_reg;
  logic [1:0]            size_reg;
  logic                  zext_reg;
  logic [ADDR_WIDTH-1:0] waddr_reg;
  logic [1:0]            lo_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic [DATA_WIDTH-1:0] align_result;

  logic req_accept;
  logic req_bad;

  assign req_accept = (state_reg == ST_IDLE) && req_valid;

  // Anything above the BRAM's byte range is out of bounds.
  assign req_bad = (req_size == SIZE_X)
                 || misaligned(req_size, req_addr[1:0])
                 || (req_addr[31:ADDR_WIDTH+2] != '0);

  assign bram_reset = rst;

  lsu_load_align u_align (
    .word     (bram_dout),
    .addr     (lo_reg),
    .size     (size_reg),
    .zero_ext (zext_reg),
    .result   (align_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Request fields are latched on acceptance so the CPU side may change them
  // freely while the access is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_reg    <= 1'b0;
      size_reg  <= SIZE_B;
      zext_reg  <= 1'b0;
      waddr_reg <= '0;
      lo_reg    <= 2'b00;
      wdata_reg <= '0;
      rdata_reg <= '0;
    end else begin
      if (req_accept) begin
        we_reg    <= req_we;
        size_reg  <= req_size;
        zext_reg  <= req_unsigned;
        waddr_reg <= req_addr[ADDR_WIDTH+1:2];
        lo_reg    <= req_addr[1:0];
        wdata_reg <= req_wdata;
      end
      // BRAM read data is valid exactly one cycle after the enable.
      if (state_reg == ST_RD_WAIT) begin
        rdata_reg <= align_result;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_err    = 1'b0;
    rsp_rdata  = '0;
    bram_en    = 1'b0;
    bram_we    = 4'b0000;
    bram_addr  = '0;
    bram_din   = '0;
    case (state_reg)
      ST_IDLE: begin
        req_ready = ~rst;
        if (req_valid) begin
          state_next = req_bad ? ST_ERR : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        bram_en   = 1'b1;
        bram_addr = waddr_reg;
        if (we_reg) begin
          bram_we    = store_we(size_reg, lo_reg);
          bram_din   = store_din(size_reg, wdata_reg);
          state_next = ST_RESP;
        end else begin
          state_next = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        state_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid  = 1'b1;
        rsp_rdata  = we_reg ? '0 : rdata_reg;
        state_next = ST_IDLE;
      end
      ST_ERR: begin
        rsp_valid  = 1'b1;
        rsp_err    = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_lsu_bram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_bram_ctrl
// Self-checking bench for lsu_bram_ctrl: a directed vector table, a reset-
// during-read sequence, and randomized requests checked against a byte-
// addressed reference memory. A simple registered-read BRAM is modelled here.
// -----------------------------------------------------------------------------
module tb_lsu_bram_ctrl;
  import lsu_pkg::*;

  localparam int AW = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [AW-1:0] bram_addr;
  logic [31:0] bram_din;
  logic [31:0] bram_dout;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic        bram_reset;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu_bram_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .bram_addr    (bram_addr),
    .bram_din     (bram_din),
    .bram_dout    (bram_dout),
    .bram_en      (bram_en),
    .bram_we      (bram_we),
    .bram_reset   (bram_reset)
  );

  // Registered-read BRAM (read-before-write), unwritten words read as 0.
  logic [31:0] bram_mem [int unsigned];

  always @(posedge clk) begin : bram_model
    logic [31:0] cur;
    int unsigned key;
    key = 32'(bram_addr);
    cur = bram_mem.exists(key) ? bram_mem[key] : 32'h0;
    if (bram_reset) begin
      bram_dout <= 32'h0;
    end else if (bram_en) begin
      bram_dout <= cur;
      if (bram_we != 4'b0000) begin
        for (int j = 0; j < 4; j++) begin
          if (bram_we[j]) cur[8*j +: 8] = bram_din[8*j +: 8];
        end
        bram_mem[key] = cur;
      end
    end
  end

  // Reference model: byte-addressed memory, accesses defined by plain byte
  // arithmetic on the CPU-visible address.
  logic [7:0] ref_mem [int unsigned];

  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic err, output logic [31:0] rdata);
    int     n;
    longint v;
    logic [7:0] b;
    err = (size == 2'b11)
       || (size == 2'b01 && (addr % 2) != 0)
       || (size == 2'b10 && (addr % 4) != 0)
       || (addr >= (32'd1 << (AW + 2)));
    rdata = 32'h0;
    if (!err) begin
      n = 1 << size;
      if (we) begin
        for (int i = 0; i < n; i++) ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < n; i++) begin
          b = ref_mem.exists(addr + 32'(i)) ? ref_mem[addr + 32'(i)] : 8'h00;
          v = v + (longint'(b) << (8 * i));
        end
        if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1)))
          v = v - (longint'(1) << (8 * n));
        rdata = v[31:0];
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Issue one request starting from a negedge with the DUT idle; observe each
  // cycle until the response (bounded), then step one more cycle.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic exp_err, output logic [31:0] exp_rdata,
                        output logic got_err, output logic [31:0] got_rdata,
                        output int got_lat, output int en_cnt, output int en_cyc,
                        output logic [3:0] en_we, output logic [31:0] en_din,
                        output logic [AW-1:0] en_addr);
    int busy_ready;
    model(we, size, uns, addr, wdata, exp_err, exp_rdata);
    chk("ready_idle", 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    got_err = 1'b0; got_rdata = 32'h0; got_lat = 0;
    en_cnt = 0; en_cyc = 0; en_we = 4'h0; en_din = 32'h0; en_addr = '0;
    busy_ready = 0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom();
    req_wdata = $urandom();
    for (int k = 1; k <= 8; k++) begin
      if (req_ready) busy_ready++;
      if (bram_en) begin
        en_cnt++; en_cyc = k; en_we = bram_we; en_din = bram_din; en_addr = bram_addr;
      end
      if (rsp_valid) begin
        got_lat = k; got_err = rsp_err; got_rdata = rsp_rdata;
        break;
      end
      @(negedge clk);
    end
    chk("ready_busy", 32'(busy_ready), 32'd0);
    @(negedge clk);
    chk("rsp_pulse", 32'(rsp_valid), 32'd0);
    $display("txn we=%0b size=%0d uns=%0b addr=0x%08h wdata=0x%08h -> err=%0b rdata=0x%08h lat=%0d",
             we, size, uns, addr, wdata, got_err, got_rdata, got_lat);
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_bwe;
    logic [31:0] exp_din;
    logic [AW-1:0] exp_baddr;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input string name, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic err, input int lat, input logic [31:0] rdata,
                         input logic [3:0] bwe, input logic [31:0] din, input logic [AW-1:0] baddr);
    vec_t v;
    v.name = name; v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_err = err; v.exp_lat = lat; v.exp_rdata = rdata; v.exp_bwe = bwe;
    v.exp_din = din; v.exp_baddr = baddr;
    tbl.push_back(v);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic        m_err, g_err;
    logic [31:0] m_rdata, g_rdata;
    int          lat, en_cnt, en_cyc;
    logic [3:0]  e_we, mask;
    logic [31:0] e_din;
    logic [AW-1:0] e_addr;
    int          rsp_seen;
    int          off, n;
    logic        r_we, r_uns;
    logic [1:0]  r_size;
    logic [31:0] r_addr, r_wdata;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;

    // Reset held for three cycles.
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    chk("rst_rsp_rdata", rsp_rdata,      32'd0);
    chk("rst_bram_en",   32'(bram_en),   32'd0);
    chk("rst_bram_we",   32'(bram_we),   32'd0);
    chk("rst_bram_addr", 32'(bram_addr), 32'd0);
    chk("rst_bram_din",  bram_din,       32'd0);
    chk("rst_bram_reset", 32'(bram_reset), 32'd1);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(req_ready), 32'd1);
    chk("bram_reset_low",  32'(bram_reset), 32'd0);
    @(negedge clk);

    //       name        we  size    uns  addr          wdata         err lat rdata         bwe      din           baddr
    add_vec("sb_13",     1, SIZE_B, 0, 32'h13,       32'h000000A5, 0, 2, 32'h0,        4'b1000, 32'hA5A5A5A5, 15'd4);
    add_vec("sh_12",     1, SIZE_H, 0, 32'h12,       32'h00001234, 0, 2, 32'h0,        4'b1100, 32'h12341234, 15'd4);
    add_vec("sw_10",     1, SIZE_W, 0, 32'h10,       32'hDEADBEEF, 0, 2, 32'h0,        4'b1111, 32'hDEADBEEF, 15'd4);
    add_vec("sw_00",     1, SIZE_W, 0, 32'h0,        32'hCAFEF00D, 0, 2, 32'h0,        4'b1111, 32'hCAFEF00D, 15'd0);
    add_vec("sb_21",     1, SIZE_B, 0, 32'h21,       32'hFFFFFF5A, 0, 2, 32'h0,        4'b0010, 32'h5A5A5A5A, 15'd8);
    add_vec("sh_1a",     1, SIZE_H, 0, 32'h1A,       32'hFFFF8001, 0, 2, 32'h0,        4'b1100, 32'h80018001, 15'd6);
    add_vec("sw_last",   1, SIZE_W, 0, 32'h1FFFC,    32'h01020304, 0, 2, 32'h0,        4'b1111, 32'h01020304, 15'h7FFF);
    add_vec("lb_13",     0, SIZE_B, 0, 32'h13,       32'h0,        0, 3, 32'hFFFFFFDE, 4'b0000, 32'h0,        15'd4);
    add_vec("lbu_13",    0, SIZE_B, 1, 32'h13,       32'h0,        0, 3, 32'h000000DE, 4'b0000, 32'h0,        15'd4);
    add_vec("lh_12",     0, SIZE_H, 0, 32'h12,       32'h0,        0, 3, 32'hFFFFDEAD, 4'b0000, 32'h0,        15'd4);
    add_vec("lhu_10",    0, SIZE_H, 1, 32'h10,       32'h0,        0, 3, 32'h0000BEEF, 4'b0000, 32'h0,        15'd4);
    add_vec("lb_11",     0, SIZE_B, 0, 32'h11,       32'h0,        0, 3, 32'hFFFFFFBE, 4'b0000, 32'h0,        15'd4);
    add_vec("lbu_10",    0, SIZE_B, 1, 32'h10,       32'h0,        0, 3, 32'h000000EF, 4'b0000, 32'h0,        15'd4);
    add_vec("lh_10",     0, SIZE_H, 0, 32'h10,       32'h0,        0, 3, 32'hFFFFBEEF, 4'b0000, 32'h0,        15'd4);
    add_vec("lw_10",     0, SIZE_W, 0, 32'h10,       32'h0,        0, 3, 32'hDEADBEEF, 4'b0000, 32'h0,        15'd4);
    add_vec("lb_21",     0, SIZE_B, 0, 32'h21,       32'h0,        0, 3, 32'h0000005A, 4'b0000, 32'h0,        15'd8);
    add_vec("lh_1a",     0, SIZE_H, 0, 32'h1A,       32'h0,        0, 3, 32'hFFFF8001, 4'b0000, 32'h0,        15'd6);
    add_vec("lw_last",   0, SIZE_W, 0, 32'h1FFFC,    32'h0,        0, 3, 32'h01020304, 4'b0000, 32'h0,        15'h7FFF);
    add_vec("lh_1fffe",  0, SIZE_H, 0, 32'h1FFFE,    32'h0,        0, 3, 32'h00000102, 4'b0000, 32'h0,        15'h7FFF);
    add_vec("err_lw_2",  0, SIZE_W, 0, 32'h2,        32'h0,        1, 1, 32'h0,        4'b0000, 32'h0,        15'd0);
    add_vec("err_sh_5",  1, SIZE_H, 0, 32'h5,        32'h1234,     1, 1, 32'h0,        4'b0000, 32'h0,        15'd0);
    add_vec("err_range", 0, SIZE_W, 0, 32'h00020000, 32'h0,        1, 1, 32'h0,        4'b0000, 32'h0,        15'd0);
    add_vec("err_size",  0, SIZE_X, 0, 32'h0,        32'h0,        1, 1, 32'h0,        4'b0000, 32'h0,        15'd0);
    add_vec("err_sw_hi", 1, SIZE_W, 0, 32'h80000000, 32'h55AA55AA, 1, 1, 32'h0,        4'b0000, 32'h0,        15'd0);

    foreach (tbl[i]) begin
      do_req(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata,
             m_err, m_rdata, g_err, g_rdata, lat, en_cnt, en_cyc, e_we, e_din, e_addr);
      chk($sformatf("%s_lat", tbl[i].name),   32'(lat),     32'(tbl[i].exp_lat));
      chk($sformatf("%s_err", tbl[i].name),   32'(g_err),   32'(tbl[i].exp_err));
      chk($sformatf("%s_rdata", tbl[i].name), g_rdata,      tbl[i].exp_rdata);
      chk($sformatf("%s_en_cnt", tbl[i].name), 32'(en_cnt), tbl[i].exp_err ? 32'd0 : 32'd1);
      if (!tbl[i].exp_err) begin
        chk($sformatf("%s_en_cyc", tbl[i].name), 32'(en_cyc), 32'd1);
        chk($sformatf("%s_bwe", tbl[i].name),    32'(e_we),   32'(tbl[i].exp_bwe));
        chk($sformatf("%s_baddr", tbl[i].name),  32'(e_addr), 32'(tbl[i].exp_baddr));
        if (tbl[i].we) chk($sformatf("%s_din", tbl[i].name), e_din, tbl[i].exp_din);
      end
    end

    // Reset while a load is waiting on BRAM data: the request must vanish.
    req_valid = 1'b1; req_we = 1'b0; req_size = SIZE_W; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("midrst_access_en", 32'(bram_en), 32'd1);
    @(negedge clk);
    chk("midrst_rdwait_en", 32'(bram_en), 32'd0);
    chk("midrst_rdwait_rsp", 32'(rsp_valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_bram_en",   32'(bram_en),   32'd0);
    chk("midrst_ready",     32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_ready_after", 32'(req_ready), 32'd1);
    rsp_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) rsp_seen++;
    end
    chk("midrst_no_rsp", 32'(rsp_seen), 32'd0);
    do_req(1'b0, SIZE_W, 1'b0, 32'h0, 32'h0,
           m_err, m_rdata, g_err, g_rdata, lat, en_cnt, en_cyc, e_we, e_din, e_addr);
    chk("post_rst_lw_lat",   32'(lat), 32'd3);
    chk("post_rst_lw_err",   32'(g_err), 32'd0);
    chk("post_rst_lw_rdata", g_rdata, 32'hCAFEF00D);

    // Randomized requests against the byte-level reference model.
    for (int t = 0; t < 300; t++) begin
      r_we   = 1'($urandom_range(0, 1));
      r_uns  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0, 1, 2: r_size = SIZE_B;
        3, 4:    r_size = SIZE_H;
        5, 6:    r_size = SIZE_W;
        default: r_size = SIZE_X;
      endcase
      case ($urandom_range(0, 15))
        0:       r_addr = $urandom();
        1:       r_addr = 32'($urandom_range(0, (1 << (AW + 2)) - 1));
        default: r_addr = 32'h100 + 32'($urandom_range(0, 31));
      endcase
      r_wdata = $urandom();
      do_req(r_we, r_size, r_uns, r_addr, r_wdata,
             m_err, m_rdata, g_err, g_rdata, lat, en_cnt, en_cyc, e_we, e_din, e_addr);
      chk("rnd_err",   32'(g_err), 32'(m_err));
      chk("rnd_rdata", g_rdata, m_rdata);
      chk("rnd_lat",   32'(lat), m_err ? 32'd1 : (r_we ? 32'd2 : 32'd3));
      chk("rnd_en_cnt", 32'(en_cnt), m_err ? 32'd0 : 32'd1);
      if (!m_err) begin
        chk("rnd_baddr", 32'(e_addr), 32'(r_addr[AW+1:2]));
        off = int'(r_addr % 4);
        n = 1 << r_size;
        mask = 4'b0000;
        if (r_we) for (int i = 0; i < n; i++) mask[off + i] = 1'b1;
        chk("rnd_bwe", 32'(e_we), 32'(mask));
        for (int j = 0; j < 4; j++) begin
          if (mask[j]) chk("rnd_din_lane", 32'(e_din[8*j +: 8]), 32'(r_wdata[8*(j - off) +: 8]));
        end
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
